ct_spsram_init_wrap: RTL and testbench

- Parametrised single-port SRAM wrapper: a behavioural array with macro-style active-low controls (CEN, GWEN, bitwise WEN).
- Adds a hardware clear engine that writes INIT_VAL to every entry, sequenced by an FSM and counter.
- The clear runs automatically after reset, or on request.
- Used for IFU/LSU tag and valid arrays that must come up invalidated without software loops.

---
 rtl/ct_spsram_pkg.sv | 13 +
 rtl/ct_spsram_init_fsm.sv | 82 ++++++++
 rtl/ct_spsram_init_wrap.sv | 78 +++++++
 tb/tb_ct_spsram_init_wrap.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_pkg.sv
// Shared types for the single-port SRAM wrapper with hardware clear.
// State encoding and the default counter width used by the clear engine.
package ct_spsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_DONE = 2'b10
    } ct_init_st_e;

    localparam int unsigned CT_CNT_W = 8;

endpackage

// File: rtl/ct_spsram_init_fsm.sv
// Clear engine: sequences INIT_VAL writes over every entry of the array.
// Owns the state, the address counter and the busy/done indications.
module ct_spsram_init_fsm
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = CT_CNT_W,
    parameter int unsigned           DEPTH      = 256,
    parameter int unsigned           DATA_WIDTH = 23,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter bit                    AUTO_INIT  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_b,
    input  logic                  i_init_req,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fn_en,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic [DATA_WIDTH-1:0] o_clr_data
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

    ct_init_st_e           r_state;
    ct_init_st_e           w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  r_busy;

    // Busy stays low in the reset-release cycle; clear writes start after it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_state <= AUTO_INIT ? ST_INIT : ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_next == ST_INIT);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_init_req) begin
                    w_next    = ST_INIT;
                    w_cnt_nxt = '0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (r_busy) begin
                    if (r_cnt == LP_LAST) begin
                        w_next    = ST_DONE;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_next    = ST_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_busy     = r_busy;
        o_done     = (r_state == ST_DONE);
        o_fn_en    = (r_state != ST_INIT);
        o_clr_we   = r_busy;
        o_clr_addr = r_cnt;
        o_clr_data = INIT_VAL;
    end

endmodule

// File: rtl/ct_spsram_init_wrap.sv
// Single-port SRAM with macro-style active-low controls and a hardware
// clear engine so tag/valid arrays come up invalidated.
module ct_spsram_init_wrap
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = CT_CNT_W,
    parameter int unsigned           DEPTH      = 256,
    parameter int unsigned           DATA_WIDTH = 23,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter bit                    AUTO_INIT  = 1'b1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  w_fn_en;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic [DATA_WIDTH-1:0] w_clr_data;
    logic                  w_in_rng;
    logic                  w_fn_rd;
    logic                  w_fn_wr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    ct_spsram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VAL   (INIT_VAL),
        .AUTO_INIT  (AUTO_INIT)
    ) u_fsm (
        .i_clk      (forever_cpuclk),
        .i_rst_b    (cpurst_b),
        .i_init_req (init_req),
        .o_busy     (init_busy),
        .o_done     (init_done),
        .o_fn_en    (w_fn_en),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_clr_data (w_clr_data)
    );

    assign w_in_rng = ({1'b0, A} < LP_DEPTH);
    assign w_fn_rd  = cpurst_b & w_fn_en & ~CEN & GWEN;
    assign w_fn_wr  = cpurst_b & w_fn_en & ~CEN & ~GWEN & w_in_rng;

    // Array has no reset; only the clear engine initialises it.
    always_ff @(posedge forever_cpuclk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= w_clr_data;
        end else if (w_fn_wr) begin
            r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_q <= '0;
        end else if (w_fn_rd) begin
            r_q <= w_in_rng ? r_mem[A] : '0;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// Randomized bench for ct_spsram_init_wrap against a behavioural array model.
// Two instances: default (auto clear, 256 deep) and 200-deep manual clear.
module tb_ct_spsram_init_wrap;

    localparam logic [22:0] IV1 = 23'h000000;
    localparam logic [22:0] IV2 = 23'h2AAAAA;

    logic        clk;
    logic        rst_b;
    logic [7:0]  a1, a2;
    logic        cen1, cen2, gwen1, gwen2, req1, req2;
    logic [22:0] wen1, wen2, d1, d2, q1, q2;
    logic        busy1, busy2, done1, done2;

    logic [22:0] m1 [256];
    logic [22:0] m2 [256];
    logic [22:0] q1e, q2e;
    int          n_chk, n_fail;

    ct_spsram_init_wrap #(
        .ADDR_WIDTH (8), .DEPTH (256), .DATA_WIDTH (23),
        .INIT_VAL (IV1), .AUTO_INIT (1'b1)
    ) u_dut1 (
        .forever_cpuclk (clk), .cpurst_b (rst_b), .A (a1), .CEN (cen1),
        .GWEN (gwen1), .WEN (wen1), .D (d1), .Q (q1), .init_req (req1),
        .init_busy (busy1), .init_done (done1)
    );

    ct_spsram_init_wrap #(
        .ADDR_WIDTH (8), .DEPTH (200), .DATA_WIDTH (23),
        .INIT_VAL (IV2), .AUTO_INIT (1'b0)
    ) u_dut2 (
        .forever_cpuclk (clk), .cpurst_b (rst_b), .A (a2), .CEN (cen2),
        .GWEN (gwen2), .WEN (wen2), .D (d2), .Q (q2), .init_req (req2),
        .init_busy (busy2), .init_done (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cen1 = 1'b1; gwen1 = 1'b1; a1 = '0; wen1 = '1; d1 = '0; req1 = 1'b0;
        cen2 = 1'b1; gwen2 = 1'b1; a2 = '0; wen2 = '1; d2 = '0; req2 = 1'b0;
    endtask

    // One functional cycle on the selected instance, model applied by rule.
    task automatic op(input bit sel, input logic cen, input logic gwen,
                      input logic [7:0] a, input logic [22:0] wen,
                      input logic [22:0] d);
        int depth;
        logic [22:0] ent;
        depth = sel ? 200 : 256;
        if (!sel) begin
            cen1 = cen; gwen1 = gwen; a1 = a; wen1 = wen; d1 = d;
        end else begin
            cen2 = cen; gwen2 = gwen; a2 = a; wen2 = wen; d2 = d;
        end
        if (!cen && gwen) begin
            ent = (int'(a) < depth) ? (sel ? m2[a] : m1[a]) : 23'h0;
            if (sel) q2e = ent;
            else q1e = ent;
        end else if (!cen && !gwen && int'(a) < depth) begin
            ent = sel ? m2[a] : m1[a];
            for (int i = 0; i < 23; i++)
                if (!wen[i]) ent[i] = d[i];
            if (sel) m2[a] = ent;
            else m1[a] = ent;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        if (sel) check("q2", q2, q2e);
        else check("q1", q1, q1e);
    endtask

    // Watch a full clear window on instance 1; optional extra request/read.
    task automatic clr1(input int len, input bit use_req, input int k2);
        int nb, nd, dat, qbad;
        nb = 0; nd = 0; dat = 0; qbad = 0;
        for (int k = 1; k <= len + 8; k++) begin
            req1 = (use_req && k == 1) || (k == k2);
            if (k == k2) begin
                cen1 = 1'b0; gwen1 = 1'b1; a1 = 8'h12;
            end
            @(posedge clk);
            #1;
            idle_inputs();
            if (busy1) nb++;
            if (done1) begin
                nd++;
                dat = k;
            end
            if (busy1 && done1) qbad++;
            if (q1 !== q1e) qbad++;
        end
        check("clr1_busy_len", nb, len);
        check("clr1_done_cnt", nd, 1);
        check("clr1_done_at", dat, len + 1);
        check("clr1_q_hold", qbad, 0);
        for (int i = 0; i < 256; i++) m1[i] = IV1;
    endtask

    task automatic clr2(input int len);
        int nb, nd, dat;
        nb = 0; nd = 0; dat = 0;
        for (int k = 1; k <= len + 8; k++) begin
            req2 = (k == 1);
            @(posedge clk);
            #1;
            idle_inputs();
            if (busy2) nb++;
            if (done2) begin
                nd++;
                dat = k;
            end
        end
        check("clr2_busy_len", nb, len);
        check("clr2_done_cnt", nd, 1);
        check("clr2_done_at", dat, len + 1);
        for (int i = 0; i < 200; i++) m2[i] = IV2;
    endtask

    task automatic rand_ops(input int n);
        logic [22:0] wen;
        for (int i = 0; i < n; i++) begin
            wen = ($urandom_range(0, 2) == 0) ? 23'h0 : 23'($urandom());
            op(1'b0, $urandom_range(0, 3) == 0, 1'($urandom()),
               8'($urandom()), wen, 23'($urandom()));
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        q1e = '0; q2e = '0;
        idle_inputs();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q1", q1, 23'h0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_q2", q2, 23'h0);
        check("rst_busy2", busy2, 1'b0);

        rst_b = 1'b1;
        clr1(256, 1'b0, 0);
        op(1'b0, 1'b0, 1'b1, 8'h00, '1, '0);
        op(1'b0, 1'b0, 1'b1, 8'hFF, '1, '0);
        check("init_val_ff", q1, IV1);

        op(1'b0, 1'b0, 1'b0, 8'h12, 23'h0, 23'h7FFFFF);
        op(1'b0, 1'b0, 1'b0, 8'h12, 23'h7FFF00, 23'h0);
        op(1'b0, 1'b0, 1'b1, 8'h12, '1, '0);
        check("mask_rd", q1, 23'h7FFF00);
        repeat (5) op(1'b0, 1'b1, 1'b1, 8'h12, '1, '0);
        op(1'b0, 1'b0, 1'b0, 8'h13, 23'h0, 23'h5A5A5A);
        check("hold_after_wr", q1, 23'h7FFF00);

        rand_ops(400);

        op(1'b0, 1'b0, 1'b0, 8'h12, 23'h0, 23'h123456);
        op(1'b0, 1'b0, 1'b1, 8'h12, '1, '0);
        clr1(256, 1'b1, 10);
        op(1'b0, 1'b0, 1'b1, 8'h12, '1, '0);
        check("cleared_12", q1, IV1);

        req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("busy_mid", busy1, 1'b1);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        q1e = '0; q2e = '0;
        check("busy_in_rst", busy1, 1'b0);
        rst_b = 1'b1;
        clr1(256, 1'b0, 0);
        rand_ops(150);

        check("busy2_idle", busy2, 1'b0);
        op(1'b1, 1'b0, 1'b0, 8'h05, 23'h0, 23'h155555);
        op(1'b1, 1'b0, 1'b1, 8'h05, '1, '0);
        clr2(200);
        op(1'b1, 1'b0, 1'b1, 8'h05, '1, '0);
        op(1'b1, 1'b0, 1'b1, 8'h00, '1, '0);
        op(1'b1, 1'b0, 1'b1, 8'hC7, '1, '0);
        check("d2_last_init", q2, IV2);
        op(1'b1, 1'b0, 1'b0, 8'hC8, 23'h0, 23'h7FFFFF);
        op(1'b1, 1'b0, 1'b0, 8'hC7, 23'h0, 23'h0F0F0F);
        op(1'b1, 1'b0, 1'b1, 8'hC7, '1, '0);
        op(1'b1, 1'b0, 1'b1, 8'hC8, '1, '0);
        check("d2_oor_rd", q2, 23'h0);
        op(1'b1, 1'b0, 1'b1, 8'hC7, '1, '0);
        op(1'b1, 1'b0, 1'b1, 8'hFF, '1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
